nibble_widen_recast: RTL
========================

Name: nibble_widen_recast

Overview:
- Sequential width up-converter: the inverse direction of our narrowing recast logic.
- Accepts a stream of IN_WIDTH-bit beats and assembles RATIO consecutive beats, LSB-first, into one OUT_WIDTH = IN_WIDTH*RATIO word.
- Valid/ready handshake on both sides; IN_LAST flushes a partial word with zero- or sign-extension.
- Sits between narrow serial datapaths (e.g. 4-bit results) and 8-bit consumers.

Parameters:
- IN_WIDTH, 4, width of one input beat.
- RATIO, 2, beats per output word (>= 2).
- SIGNED, 0, partial-word fill: 0 = zero-fill, 1 = replicate MSB of the last accepted beat.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- IN_DATA  input  IN_WIDTH  input beat.
- IN_VALID  input  1  IN_DATA valid.
- IN_LAST  input  1  beat closes the current word (partial flush).
- IN_READY  output  1  block accepts a beat this cycle.
- OUT_DATA  output  IN_WIDTH*RATIO  assembled word.
- OUT_BEATS  output  clog2(RATIO+1)  number of real beats in OUT_DATA (1..RATIO).
- OUT_VALID  output  1  OUT_DATA valid.
- OUT_READY  input  1  consumer takes the word.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high on RST.
- Reset values: OUT_VALID=0, OUT_DATA=0, OUT_BEATS=0, beat counter CNT=0, accumulator=0. IN_READY=0 while RST=1.
- Handshakes:
  - Input beat accepted when IN_VALID & IN_READY.
  - Output word transferred when OUT_VALID & OUT_READY.
  - IN_READY = !RST & (!OUT_VALID | OUT_READY). It does not depend on IN_VALID or IN_LAST.
- State, implicit in CNT (0..RATIO-1):
  - EMPTY: CNT=0.
  - FILL: CNT>0.
  - Output register state: OUT_VALID.
- Accepted beat placement: the beat is written to accumulator slice [CNT*IN_WIDTH +: IN_WIDTH].
- Completion occurs when CNT==RATIO-1 or IN_LAST=1:
  - The next cycle, OUT_DATA = accumulator with this beat merged in. Slices above CNT are filled with zeros (SIGNED=0) or with the beat's MSB replicated (SIGNED=1).
  - OUT_BEATS = CNT+1; OUT_VALID=1; CNT returns to 0.
  - Latency: 1 cycle from the completing beat to OUT_VALID.
- Non-completing beat: CNT increments; outputs unchanged.
- Sustained throughput: one beat per cycle when OUT_READY=1. Back-to-back words run with no bubble because a transfer and a completing beat may occur in the same cycle; the new word replaces the old one.
- Transfer with no completing beat: OUT_VALID drops to 0 next cycle. OUT_DATA and OUT_BEATS hold their last values.
- Backpressure (OUT_VALID=1 & OUT_READY=0):
  - IN_READY=0.
  - OUT_DATA, OUT_BEATS and the partial accumulator are held stable.
- IN_LAST on the RATIO-th beat behaves as a normal full word (OUT_BEATS=RATIO).
- IN_VALID=0: no state change apart from output transfer.
- Reset mid-fill or with OUT_VALID=1: partial data and the pending word are discarded. All state goes to reset values the next cycle, and no word is emitted.
- Arithmetic: CNT compare/increment is unsigned at width clog2(RATIO). Fill and extension are pure bit replication with no arithmetic on data.

Test Plan:
- Reset release: RST high 2 cycles, then low -> OUT_VALID=0, OUT_DATA=0x00, OUT_BEATS=0; IN_READY=0 during reset and 1 afterwards.
- Full word: beats 0x3 then 0xC on consecutive cycles, OUT_READY=1 -> one cycle after 0xC, OUT_DATA=0xC3, OUT_BEATS=2, OUT_VALID=1 for one cycle.
- Streaming: 0x1,0x2,0x3,0x4 back-to-back, OUT_READY=1 -> words 0x21 then 0x43 on alternate cycles; IN_READY stays 1 throughout.
- Partial flush: single beat 0xA with IN_LAST=1 -> SIGNED=0 gives OUT_DATA=0x0A, OUT_BEATS=1; SIGNED=1 gives 0xFA.
- Backpressure: word 0x5E pending, OUT_READY=0 for 3 cycles, IN_VALID=1 with 0x7 -> IN_READY=0 and OUT_DATA=0x5E stable. When OUT_READY rises, 0x7 is accepted in that same cycle.
- Reset mid-fill: accept 0x9, assert RST one cycle, then send 0x1,0x2 -> OUT_DATA=0x21; the 0x9 never appears.

Source files
------------

// File: rtl/nibble_widen_recast.sv
// nibble_widen_recast: gathers RATIO narrow beats (LSB-first) into one wide
// word. IN_LAST closes a word early; the unused upper slices are zero-filled
// or filled with copies of the last beat's MSB.
//
// Handshake rules, both sides: a beat/word moves on a rising edge where
// valid & ready are both high. Valid never depends on ready. IN_READY depends
// only on RST, OUT_VALID and OUT_READY, never on IN_VALID or IN_LAST.
module nibble_widen_recast #(
  parameter int IN_WIDTH = 4,
  parameter int RATIO    = 2,
  parameter int SIGNED   = 0,
  localparam int OUT_WIDTH = IN_WIDTH * RATIO,
  localparam int CNT_W     = $clog2(RATIO),
  localparam int BEATS_W   = $clog2(RATIO + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [IN_WIDTH-1:0]  IN_DATA,
  input  logic                 IN_VALID,
  input  logic                 IN_LAST,
  output logic                 IN_READY,
  output logic [OUT_WIDTH-1:0] OUT_DATA,
  output logic [BEATS_W-1:0]   OUT_BEATS,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  // Beat counter, exposed so EMPTY (0) / FILL (>0) can be observed directly.
  output logic [CNT_W-1:0]     dbg_cnt
);

  logic [CNT_W-1:0]     cnt;
  logic [OUT_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0] merged;
  logic [IN_WIDTH-1:0]  fill;
  logic                 accept;
  logic                 complete;
  logic                 transfer;

  assign dbg_cnt = cnt;

  // The output register can take a new word when it is empty or being drained.
  always_comb begin
    IN_READY = !RST && (!OUT_VALID || OUT_READY);
    accept   = IN_VALID && IN_READY;
    transfer = OUT_VALID && OUT_READY;
    complete = accept && ((cnt == CNT_W'(RATIO - 1)) || IN_LAST);
  end

  // Word as it would look if the current beat closes it: stored slices below
  // the counter, the beat at the counter, extension fill above it.
  always_comb begin
    merged = '0;
    fill   = (SIGNED != 0) ? {IN_WIDTH{IN_DATA[IN_WIDTH-1]}} : '0;
    for (int i = 0; i < RATIO; i++) begin
      if (i < int'(cnt))
        merged[i*IN_WIDTH +: IN_WIDTH] = acc[i*IN_WIDTH +: IN_WIDTH];
      else if (i == int'(cnt))
        merged[i*IN_WIDTH +: IN_WIDTH] = IN_DATA;
      else
        merged[i*IN_WIDTH +: IN_WIDTH] = fill;
    end
  end

  // Counter, accumulator and output register; a completing beat may load a
  // new word in the same cycle the previous one is transferred.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt       <= '0;
      acc       <= '0;
      OUT_DATA  <= '0;
      OUT_BEATS <= '0;
      OUT_VALID <= 1'b0;
    end else if (complete) begin
      OUT_DATA  <= merged;
      OUT_BEATS <= BEATS_W'(int'(cnt) + 1);
      OUT_VALID <= 1'b1;
      cnt       <= '0;
      acc       <= '0;
    end else begin
      if (transfer)
        OUT_VALID <= 1'b0;
      if (accept) begin
        acc[cnt*IN_WIDTH +: IN_WIDTH] <= IN_DATA;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule
